// File: rtl/des_pkg.sv
// DES initial/final permutation tables, the per-beat mode encoding and a
// generic table-driven bit permutation shared by the streaming permuter.
package des_pkg;

  typedef enum logic [1:0] {
    MODE_IP     = 2'b00,
    MODE_FP     = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  typedef int perm_table_t [64];

  // Entry k-1 is the 1-based DES source bit that lands on output DES bit k.
  localparam perm_table_t IP_TABLE = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam perm_table_t FP_TABLE = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  // DES bit n lives at vector index 64-n, so bit 1 is the MSB.
  function automatic logic [63:0] permute(input logic [63:0] blk, input perm_table_t tbl);
    logic [63:0] res;
    logic [5:0]  src;
    logic [5:0]  dst;
    res = '0;
    for (int k = 0; k < 64; k++) begin
      src      = 6'(64 - tbl[k]);
      dst      = 6'(63 - k);
      res[dst] = blk[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/des_pipe_stage.sv
// Single elastic register stage: holds one beat and refills in the same
// cycle it drains, so a chain of these sustains one beat per clock.
module des_pipe_stage #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic         full;
  logic [W-1:0] data;
  logic         stage_ready;

  assign stage_ready = !full || dn_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (stage_ready) begin
      full <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

  assign dn_valid = full;
  assign dn_data  = data;

endmodule

// File: rtl/des_perm_stream.sv
// Streaming DES IP/FP permuter: each beat carries LANES 64-bit blocks that are
// permuted combinationally and then travel through STAGES elastic registers.
module des_perm_stream
  import des_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            mode_i,
  input  logic [64*LANES-1:0]   block_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [64*LANES-1:0]   block_o,
  output logic [1:0]            mode_o,
  input  logic                  clear_i,
  output logic [CNT_W-1:0]      count_o
);

  localparam int W = 64 * LANES + 2;

  if (LANES < 1 || LANES > 8 || STAGES < 1 || STAGES > 4) begin : g_bad_param
    $error("des_perm_stream: LANES must be 1..8 and STAGES 1..4");
  end

  logic [64*LANES-1:0] permuted;
  logic                chain_valid [0:STAGES];
  logic [W-1:0]        chain_data  [0:STAGES];
  logic                rdy         [0:STAGES];
  logic [CNT_W-1:0]    count;

  // Modes 10 and 11 fall through to the default and leave lanes untouched.
  always_comb begin
    permuted = block_i;
    for (int k = 0; k < LANES; k++) begin
      case (mode_e'(mode_i))
        MODE_IP: permuted[64*k +: 64] = permute(block_i[64*k +: 64], IP_TABLE);
        MODE_FP: permuted[64*k +: 64] = permute(block_i[64*k +: 64], FP_TABLE);
        default: ;
      endcase
    end
  end

  // Ready ripples back from the sink; a stage is ready if empty or draining.
  always_comb begin
    rdy[STAGES] = ready_i;
    for (int s = STAGES - 1; s >= 0; s--) begin
      rdy[s] = !chain_valid[s+1] || rdy[s+1];
    end
  end

  assign chain_valid[0] = valid_i;
  assign chain_data[0]  = {mode_i, permuted};
  assign ready_o        = rdy[0] && !rst_i;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    des_pipe_stage #(
      .W(W)
    ) u_stage (
      .clk     (clk_i),
      .rst     (rst_i),
      .up_valid(chain_valid[s]),
      .up_data (chain_data[s]),
      .dn_valid(chain_valid[s+1]),
      .dn_ready(rdy[s+1]),
      .dn_data (chain_data[s+1])
    );
  end

  assign valid_o = chain_valid[STAGES];
  assign mode_o  = chain_data[STAGES][W-1 -: 2];
  assign block_o = chain_data[STAGES][64*LANES-1:0];

  // Clear takes priority over a coinciding output transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (valid_o && ready_i) begin
      count <= count + CNT_W'(1);
    end
  end

  assign count_o = count;

endmodule

// File: tb/tb_des_perm_stream.sv
// Self-checking bench for des_perm_stream: three instances cover the single
// stage, the deep two-lane pipeline and the narrow counter configurations.
module tb_des_perm_stream;

  localparam int IP_REF [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic        a_valid_i, a_ready_o, a_valid_o, a_ready_i, a_clear_i;
  logic [1:0]  a_mode_i, a_mode_o;
  logic [63:0] a_block_i, a_block_o;
  logic [31:0] a_count_o;

  logic         b_valid_i, b_ready_o, b_valid_o, b_ready_i, b_clear_i;
  logic [1:0]   b_mode_i, b_mode_o;
  logic [127:0] b_block_i, b_block_o;
  logic [31:0]  b_count_o;

  logic        c_valid_i, c_ready_o, c_valid_o, c_ready_i, c_clear_i;
  logic [1:0]  c_mode_i, c_mode_o;
  logic [63:0] c_block_i, c_block_o;
  logic [3:0]  c_count_o;

  des_perm_stream #(.LANES(1), .STAGES(1), .CNT_W(32)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .mode_i(a_mode_i), .block_i(a_block_i), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .block_o(a_block_o), .mode_o(a_mode_o), .clear_i(a_clear_i), .count_o(a_count_o)
  );

  des_perm_stream #(.LANES(2), .STAGES(3), .CNT_W(32)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .mode_i(b_mode_i), .block_i(b_block_i), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .block_o(b_block_o), .mode_o(b_mode_o), .clear_i(b_clear_i), .count_o(b_count_o)
  );

  des_perm_stream #(.LANES(1), .STAGES(1), .CNT_W(4)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .valid_i(c_valid_i), .ready_o(c_ready_o),
    .mode_i(c_mode_i), .block_i(c_block_i), .valid_o(c_valid_o), .ready_i(c_ready_i),
    .block_o(c_block_o), .mode_o(c_mode_o), .clear_i(c_clear_i), .count_o(c_count_o)
  );

  // FP is modelled by scattering through IP rather than a second table.
  function automatic logic [63:0] ref_lane(input logic [1:0] mode, input logic [63:0] x);
    logic [63:0] r;
    logic [5:0]  dst;
    logic [5:0]  src;
    r = x;
    if (mode == 2'b00) begin
      for (int k = 1; k <= 64; k++) begin
        dst = 6'(64 - k);
        src = 6'(64 - IP_REF[k-1]);
        r[dst] = x[src];
      end
    end else if (mode == 2'b01) begin
      for (int k = 1; k <= 64; k++) begin
        dst = 6'(64 - IP_REF[k-1]);
        src = 6'(64 - k);
        r[dst] = x[src];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_beat2(input logic [1:0] mode, input logic [127:0] x);
    return {ref_lane(mode, x[127:64]), ref_lane(mode, x[63:0])};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (a_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_valid: got %b want 0", a_valid_o); end
    checks++; if (a_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_a_ready: got %b want 0", a_ready_o); end
    checks++; if (a_block_o !== 64'h0) begin errors++; $display("[TB] FAIL reset_a_block: got %h want 0", a_block_o); end
    checks++; if (a_mode_o !== 2'b00) begin errors++; $display("[TB] FAIL reset_a_mode: got %b want 00", a_mode_o); end
    checks++; if (a_count_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_a_count: got %0d want 0", a_count_o); end
    checks++; if (b_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_valid: got %b want 0", b_valid_o); end
    checks++; if (b_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_b_ready: got %b want 0", b_ready_o); end
    checks++; if (b_block_o !== 128'h0) begin errors++; $display("[TB] FAIL reset_b_block: got %h want 0", b_block_o); end
    checks++; if (c_count_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_c_count: got %0d want 0", c_count_o); end
    rst = 1'b0;
    #1;
    checks++; if (a_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL release_a_ready: got %b want 1", a_ready_o); end
    checks++; if (b_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL release_b_ready: got %b want 1", b_ready_o); end
  endtask

  task automatic test_ip();
    @(negedge clk);
    a_ready_i = 1'b1; a_mode_i = 2'b00; a_block_i = 64'h0123456789ABCDEF; a_valid_i = 1'b1;
    @(negedge clk);
    a_valid_i = 1'b0;
    checks++; if (a_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL ip_valid: got %b want 1", a_valid_o); end
    checks++; if (a_block_o !== 64'hCC00CCFFF0AAF0AA) begin errors++; $display("[TB] FAIL ip_block: got %h want cc00ccfff0aaf0aa", a_block_o); end
    checks++; if (a_mode_o !== 2'b00) begin errors++; $display("[TB] FAIL ip_mode: got %b want 00", a_mode_o); end
    @(negedge clk);
    checks++; if (a_count_o !== 32'd1) begin errors++; $display("[TB] FAIL ip_count: got %0d want 1", a_count_o); end
    checks++; if (a_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ip_drain: got %b want 0", a_valid_o); end
  endtask

  task automatic test_fp();
    @(negedge clk);
    a_mode_i = 2'b01; a_block_i = 64'hCC00CCFFF0AAF0AA; a_valid_i = 1'b1;
    @(negedge clk);
    a_valid_i = 1'b0;
    checks++; if (a_block_o !== 64'h0123456789ABCDEF) begin errors++; $display("[TB] FAIL fp_block: got %h want 0123456789abcdef", a_block_o); end
    checks++; if (a_mode_o !== 2'b01) begin errors++; $display("[TB] FAIL fp_mode: got %b want 01", a_mode_o); end
    @(negedge clk);
    checks++; if (a_count_o !== 32'd2) begin errors++; $display("[TB] FAIL fp_count: got %0d want 2", a_count_o); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    a_mode_i = 2'b10; a_block_i = 64'hFFFF0000AAAA5555; a_valid_i = 1'b1;
    @(negedge clk);
    checks++; if (a_block_o !== 64'hFFFF0000AAAA5555 || a_mode_o !== 2'b10) begin
      errors++; $display("[TB] FAIL bypass_10: got %h/%b want ffff0000aaaa5555/10", a_block_o, a_mode_o); end
    a_mode_i = 2'b11;
    @(negedge clk);
    a_valid_i = 1'b0;
    checks++; if (a_block_o !== 64'hFFFF0000AAAA5555 || a_mode_o !== 2'b11) begin
      errors++; $display("[TB] FAIL bypass_11: got %h/%b want ffff0000aaaa5555/11", a_block_o, a_mode_o); end
    @(negedge clk);
    checks++; if (a_count_o !== 32'd4) begin errors++; $display("[TB] FAIL bypass_count: got %0d want 4", a_count_o); end
  endtask

  task automatic test_random_modes();
    logic [63:0] exp_blk;
    logic [1:0]  exp_mode;
    exp_blk = '0; exp_mode = '0;
    for (int j = 0; j <= 16; j++) begin
      @(negedge clk);
      if (j > 0) begin
        checks++;
        if (a_valid_o !== 1'b1 || a_block_o !== exp_blk || a_mode_o !== exp_mode) begin
          errors++; $display("[TB] FAIL random_a beat %0d: got %b/%h/%b want 1/%h/%b", j-1, a_valid_o, a_block_o, a_mode_o, exp_blk, exp_mode);
        end
      end
      if (j < 16) begin
        a_mode_i = 2'($urandom_range(0, 3)); a_block_i = rand64(); a_valid_i = 1'b1;
        exp_mode = a_mode_i; exp_blk = ref_lane(a_mode_i, a_block_i);
      end else begin
        a_valid_i = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (a_count_o !== 32'd20) begin errors++; $display("[TB] FAIL random_a_count: got %0d want 20", a_count_o); end
  endtask

  task automatic test_backpressure();
    logic [129:0] exp_q[$];
    logic [129:0] exp;
    logic [127:0] hold_blk;
    logic [1:0]   hold_mode;
    logic         stall;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; stall = 1'b0; hold_blk = '0; hold_mode = '0;
    while (recv < 20 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        checks++;
        if (b_valid_o !== 1'b1 || b_block_o !== hold_blk || b_mode_o !== hold_mode) begin
          errors++; $display("[TB] FAIL stall_hold: got %b/%h/%b want 1/%h/%b", b_valid_o, b_block_o, b_mode_o, hold_blk, hold_mode);
        end
      end
      b_ready_i = ($urandom_range(0, 9) < 6);
      b_valid_i = (sent < 20) && ($urandom_range(0, 3) != 0);
      b_mode_i  = 2'($urandom_range(0, 3));
      b_block_i = {rand64(), rand64()};
      #1;
      if (b_valid_i && b_ready_o) begin
        exp_q.push_back({b_mode_i, ref_beat2(b_mode_i, b_block_i)});
        sent++;
      end
      if (b_valid_o && b_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL bp_order: got unexpected beat %h want none", b_block_o);
        end else begin
          exp = exp_q.pop_front();
          if ({b_mode_o, b_block_o} !== exp) begin
            errors++; $display("[TB] FAIL bp_data beat %0d: got %h want %h", recv, {b_mode_o, b_block_o}, exp);
          end
        end
        recv++;
      end
      stall = b_valid_o && !b_ready_i; hold_blk = b_block_o; hold_mode = b_mode_o;
    end
    if (recv < 20) begin
      checks++; errors++; $display("[TB] FAIL bp_timeout: got %0d beats want 20", recv);
    end
    b_valid_i = 1'b0; b_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (b_count_o !== 32'd20) begin errors++; $display("[TB] FAIL bp_count: got %0d want 20", b_count_o); end
    checks++; if (b_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: got %b want 0", b_valid_o); end
  endtask

  task automatic test_latency();
    logic [127:0] exp_blk;
    @(negedge clk);
    b_ready_i = 1'b1; b_mode_i = 2'b00; b_block_i = {rand64(), rand64()}; b_valid_i = 1'b1;
    exp_blk = ref_beat2(2'b00, b_block_i);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      b_valid_i = 1'b0;
      checks++;
      if (b_valid_o !== (n == 3)) begin
        errors++; $display("[TB] FAIL latency cycle %0d: got %b want %b", n, b_valid_o, (n == 3));
      end
      if (n == 3) begin
        checks++; if (b_block_o !== exp_blk) begin errors++; $display("[TB] FAIL latency_data: got %h want %h", b_block_o, exp_blk); end
      end
    end
  endtask

  task automatic test_bubble_collapse();
    logic [127:0] exp_blk [3];
    b_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_mode_i = 2'($urandom_range(0, 3)); b_block_i = {rand64(), rand64()}; b_valid_i = 1'b1;
      #1;
      checks++;
      if (b_ready_o !== (i < 3)) begin errors++; $display("[TB] FAIL bubble_ready %0d: got %b want %b", i, b_ready_o, (i < 3)); end
      if (i < 3) exp_blk[i] = ref_beat2(b_mode_i, b_block_i);
    end
    @(negedge clk);
    b_valid_i = 1'b0; b_ready_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) @(negedge clk);
      checks++;
      if (b_valid_o !== 1'b1 || b_block_o !== exp_blk[j]) begin
        errors++; $display("[TB] FAIL bubble_drain %0d: got %b/%h want 1/%h", j, b_valid_o, b_block_o, exp_blk[j]);
      end
    end
    @(negedge clk);
    checks++; if (b_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bubble_no_extra: got %b want 0", b_valid_o); end
  endtask

  task automatic test_reset_midstream();
    b_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_mode_i = 2'b00; b_block_i = {rand64(), rand64()}; b_valid_i = 1'b1;
    end
    @(negedge clk);
    b_valid_i = 1'b0;
    checks++; if (b_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre: got %b want 1", b_valid_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (b_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b want 0", b_valid_o); end
    checks++; if (b_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ready: got %b want 0", b_ready_o); end
    checks++; if (b_block_o !== 128'h0 || b_mode_o !== 2'b00) begin errors++; $display("[TB] FAIL midrst_data: got %h/%b want 0/00", b_block_o, b_mode_o); end
    checks++; if (b_count_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_b_count: got %0d want 0", b_count_o); end
    checks++; if (a_count_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_a_count: got %0d want 0", a_count_o); end
    @(negedge clk);
    rst = 1'b0; b_ready_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++; if (b_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale cycle %0d: got %b want 0", n, b_valid_o); end
    end
    checks++; if (b_count_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_count_after: got %0d want 0", b_count_o); end
  endtask

  task automatic test_counter();
    c_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      c_mode_i = 2'($urandom_range(0, 3)); c_block_i = rand64(); c_valid_i = 1'b1;
    end
    @(negedge clk);
    c_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (c_count_o !== 4'd1) begin errors++; $display("[TB] FAIL count_wrap: got %0d want 1", c_count_o); end
    c_block_i = rand64(); c_valid_i = 1'b1;
    @(negedge clk);
    c_valid_i = 1'b0; c_clear_i = 1'b1;
    checks++; if (c_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL clear_pre: got %b want 1", c_valid_o); end
    @(negedge clk);
    c_clear_i = 1'b0;
    checks++; if (c_count_o !== 4'd0) begin errors++; $display("[TB] FAIL clear_wins: got %0d want 0", c_count_o); end
  endtask

  initial begin
    rst = 1'b1;
    a_valid_i = 1'b0; a_ready_i = 1'b1; a_clear_i = 1'b0; a_mode_i = 2'b00; a_block_i = '0;
    b_valid_i = 1'b0; b_ready_i = 1'b1; b_clear_i = 1'b0; b_mode_i = 2'b00; b_block_i = '0;
    c_valid_i = 1'b0; c_ready_i = 1'b1; c_clear_i = 1'b0; c_mode_i = 2'b00; c_block_i = '0;
    test_reset();
    test_ip();
    test_fp();
    test_bypass();
    test_random_modes();
    test_backpressure();
    test_latency();
    test_bubble_collapse();
    test_reset_midstream();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
